fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter in the SIC-4 core.
- Accepts the 8-bit PC with a valid/ready handshake and issues reads to synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions, each tagged with its PC, in a small FIFO toward decode.
- Provides backpressure to the PC (PC holds while pc_ready=0) and a flush for taken branches.

---
 rtl/sic4_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sic4_pkg.sv
// Shared SIC-4 core definitions: datapath widths, memory latency and the
// fetch-to-decode entry type.
package sic4_pkg;

  localparam int ADDR_W   = 8;
  localparam int INST_W   = 16;
  localparam int IMEM_LAT = 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a single-cycle clear.
// Occupancy state is reset; the storage array is not.
module fetch_fifo
  import sic4_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_din,
  input  logic               i_pop,
  input  logic               i_clear,
  output fetch_entry_t       o_head,
  output logic [CNT_W-1:0]   o_count
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push & (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop  & (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// SIC-4 instruction fetch: accepts PCs, reads synchronous instruction memory
// and buffers {inst, pc} entries toward decode, with flush for taken branches.
module fetch_stage
  import sic4_pkg::*;
#(
  parameter int ADDR_W = sic4_pkg::ADDR_W,
  parameter int INST_W = sic4_pkg::INST_W,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              flush,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              r_inflight;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;

  // Reserving a slot for the in-flight read guarantees the return always fits.
  assign w_occ      = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign pc_ready   = (w_occ < (CNT_W + 1)'(DEPTH)) & ~flush;
  assign w_accept   = pc_valid & pc_ready;

  assign imem_en    = w_accept;
  assign imem_addr  = pc_in;

  assign w_push       = r_inflight & ~flush;
  assign w_push_entry = '{inst: imem_rdata, pc: r_pend_pc};

  assign w_nonempty = (w_count != '0);
  assign inst_valid = w_nonempty & ~flush;
  assign w_pop      = inst_valid & inst_ready;
  assign inst_out   = w_nonempty ? w_head.inst : '0;
  assign inst_pc    = w_nonempty ? w_head.pc   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pend_pc <= pc_in;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (flush),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage with a queue-based reference
// model of the fetch pipeline and a negedge monitor.
module tb_fetch_stage;
  import sic4_pkg::*;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic [15:0] inst_out;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_W(8), .INST_W(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of PCs whose instructions are buffered, plus the
  // one read that may be in flight.
  logic [7:0] exp_q[$];
  logic       pend_v = 1'b0;
  logic [7:0] pend_pc = '0;

  always @(negedge clk) begin
    logic exp_rdy, exp_vld, exp_acc;
    int   occ;
    if (!rst_n) begin
      exp_q.delete();
      pend_v = 1'b0;
    end else begin
      occ     = exp_q.size() + (pend_v ? 1 : 0);
      exp_rdy = (occ < DEPTH) && !flush;
      exp_vld = (exp_q.size() != 0) && !flush;
      exp_acc = pc_valid && exp_rdy;
      chk("pc_ready", 32'(pc_ready), 32'(exp_rdy));
      chk("inst_valid", 32'(inst_valid), 32'(exp_vld));
      chk("imem_en", 32'(imem_en), 32'(exp_acc));
      if (exp_acc) chk("imem_addr", 32'(imem_addr), 32'(pc_in));
      if (exp_vld) begin
        chk("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
        chk("inst_out", 32'(inst_out), 32'(rom(exp_q[0])));
      end
      if (flush) begin
        exp_q.delete();
        pend_v = 1'b0;
      end else begin
        if (exp_vld && inst_ready) void'(exp_q.pop_front());
        if (pend_v) exp_q.push_back(pend_pc);
        pend_v  = exp_acc;
        pend_pc = pc_in;
      end
    end
  end

  // Drive one cycle (called at posedge+1) and sample outputs at the negedge.
  task automatic drive(input logic v, input logic [7:0] pc, input logic rdy,
                       input logic fl, output logic acc, output logic vld_s,
                       output logic [7:0] pc_s, output logic [15:0] inst_s);
    pc_valid   = v;
    pc_in      = pc;
    inst_ready = rdy;
    flush      = fl;
    @(negedge clk);
    acc    = v & pc_ready & ~fl;
    vld_s  = inst_valid;
    pc_s   = inst_pc;
    inst_s = inst_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic a, vs;
    logic [7:0] ps;
    logic [15:0] is;
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, a, vs, ps, is);
  endtask

  initial begin
    logic        acc, vs, hold, rv, rdy, fl;
    logic [7:0]  pc, ps, rpc;
    logic [15:0] is;
    int          blocked;

    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", 32'(inst_out), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);
    chk("rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty pops are ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, acc, vs, ps, is);
      chk("empty_valid", 32'(vs), 32'd0);
    end

    // Streaming: latency 2, one per cycle, no stall.
    pc = 8'd0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, pc, 1'b1, 1'b0, acc, vs, ps, is);
      chk("stream_ready", 32'(acc), 32'd1);
      if (i < 2) chk("stream_lat_early", 32'(vs), 32'd0);
      if (i == 2) begin
        chk("stream_first_valid", 32'(vs), 32'd1);
        chk("stream_first_pc", 32'(ps), 32'd0);
        chk("stream_first_inst", 32'(is), 32'h1000);
      end
      if (acc) pc++;
    end
    drain();

    // Backpressure then release.
    pc = 8'd0;
    blocked = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, pc, (i < 3), 1'b0, acc, vs, ps, is);
      if (acc) pc++; else blocked++;
    end
    chk("bp_stalled", 32'(blocked != 0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pc, 1'b1, 1'b0, acc, vs, ps, is);
      if (acc) pc++;
    end
    drain();

    // Flush with a read in flight.
    drive(1'b1, 8'd4, 1'b1, 1'b0, acc, vs, ps, is);
    drive(1'b1, 8'd5, 1'b1, 1'b0, acc, vs, ps, is);
    drive(1'b1, 8'd20, 1'b1, 1'b1, acc, vs, ps, is);
    chk("flush_no_accept", 32'(acc), 32'd0);
    chk("flush_no_valid", 32'(vs), 32'd0);
    drive(1'b1, 8'd20, 1'b1, 1'b0, acc, vs, ps, is);
    chk("flush_accept_20", 32'(acc), 32'd1);
    chk("flush_empty_after", 32'(vs), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, acc, vs, ps, is);
    chk("flush_lat1", 32'(vs), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, acc, vs, ps, is);
    chk("flush_out_valid", 32'(vs), 32'd1);
    chk("flush_out_pc", 32'(ps), 32'd20);
    chk("flush_out_inst", 32'(is), 32'h1014);
    drain();

    // Fill to full, then a single pop advances the head by one.
    pc = 8'd30;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pc, 1'b0, 1'b0, acc, vs, ps, is);
      if (acc) pc++;
    end
    chk("full_blocked", 32'(acc), 32'd0);
    chk("full_head", 32'(ps), 32'd30);
    drive(1'b1, pc, 1'b1, 1'b0, acc, vs, ps, is);
    chk("full_pop_noaccept", 32'(acc), 32'd0);
    drive(1'b1, pc, 1'b0, 1'b0, acc, vs, ps, is);
    chk("full_head_adv", 32'(ps), 32'd31);
    chk("full_reaccept", 32'(acc), 32'd1);
    drain();

    // Randomized traffic with occasional flushes.
    hold = 1'b0;
    rv   = 1'b0;
    rpc  = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        rv  = ($urandom_range(0, 9) < 7);
        rpc = 8'($urandom);
      end
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      drive(rv, rpc, rdy, fl, acc, vs, ps, is);
      hold = rv && !acc;
    end
    drain();

    // Async reset with count=2, inflight=1.
    drive(1'b1, 8'd6, 1'b0, 1'b0, acc, vs, ps, is);
    drive(1'b1, 8'd7, 1'b0, 1'b0, acc, vs, ps, is);
    drive(1'b1, 8'd8, 1'b0, 1'b0, acc, vs, ps, is);
    chk("pre_reset_accept", 32'(acc), 32'd1);
    pc_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(inst_valid), 32'd0);
    chk("areset_ready", 32'(pc_ready), 32'd1);
    chk("areset_inst_pc", 32'(inst_pc), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'd9, 1'b1, 1'b0, acc, vs, ps, is);
    chk("post_reset_accept", 32'(acc), 32'd1);
    chk("post_reset_stale", 32'(vs), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, acc, vs, ps, is);
    chk("post_reset_lat1", 32'(vs), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, acc, vs, ps, is);
    chk("post_reset_valid", 32'(vs), 32'd1);
    chk("post_reset_pc", 32'(ps), 32'd9);
    chk("post_reset_inst", 32'(is), 32'h1009);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
